// File: rtl/seq_multiplier.sv
// Sequential shift-add 8x8 multiplier, signed or unsigned.
// One multiplier bit per clock; start/ready handshake.
module seq_multiplier #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic [15:0] product,
  output logic        ready,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic        neg;
  logic        accept;
  logic [7:0]  mag_a;
  logic [7:0]  mag_b;

  assign ready  = (state == IDLE) || (state == DONE);
  assign accept = ready && start;

  // Operand magnitudes; 0x80 maps to 128 in 8 unsigned bits.
  always_comb begin
    mag_a = multiplicand;
    mag_b = multiplier;
    if (SIGNED && multiplicand[7]) mag_a = ~multiplicand + 8'd1;
    if (SIGNED && multiplier[7])   mag_b = ~multiplier + 8'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == 4'd1) state_nx = SIGN;
      SIGN:    state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: load, shift-add iterations, sign fix-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mcand  <= {8'd0, mag_a};
        mplier <= mag_b;
        acc    <= '0;
        cnt    <= 4'd8;
        neg    <= SIGNED ? (multiplicand[7] ^ multiplier[7]) : 1'b0;
      end else if (state == RUN) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 4'd1;
      end else if (state == SIGN) begin
        product <= neg ? (~acc + 16'd1) : acc;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier.
// Signed and unsigned instances share stimulus.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] product_s;
  logic        ready_s;
  logic        done_s;
  logic [15:0] product_u;
  logic        ready_u;
  logic        done_u;

  int checks;
  int failures;
  logic [15:0] prev_s;
  logic [15:0] prev_u;

  seq_multiplier #(.SIGNED(1'b1)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product(product_s), .ready(ready_s), .done(done_s)
  );

  seq_multiplier #(.SIGNED(1'b0)) u_u (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product(product_u), .ready(ready_u), .done(done_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mul_s(input logic [7:0] a, input logic [7:0] b);
    int x;
    int y;
    x = int'($signed(a));
    y = int'($signed(b));
    return 16'(x * y);
  endfunction

  function automatic logic [15:0] mul_u(input logic [7:0] a, input logic [7:0] b);
    int x;
    int y;
    x = int'(a);
    y = int'(b);
    return 16'(x * y);
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start an operation at the current time (#1 after an edge);
  // hold keeps start high and scrambles operands during the run;
  // chain leaves the caller to issue the next start at E10.
  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input bit hold, input bit chain);
    logic [15:0] es;
    logic [15:0] eu;
    es = mul_s(a, b);
    eu = mul_u(a, b);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    @(posedge clk); #1;
    chk("e0_ready_s", 16'(ready_s), 16'd0);
    chk("e0_ready_u", 16'(ready_u), 16'd0);
    chk("e0_done", 16'(done_s), 16'd0);
    chk("e0_hold_s", product_s, prev_s);
    start = hold;
    for (int i = 1; i <= 8; i++) begin
      multiplicand = 8'($urandom);
      multiplier = 8'($urandom);
      @(posedge clk); #1;
      chk("run_ready", 16'(ready_s), 16'd0);
      chk("run_done", 16'({done_s, done_u}), 16'd0);
      chk("run_hold_s", product_s, prev_s);
      chk("run_hold_u", product_u, prev_u);
    end
    @(posedge clk); #1;
    chk("e9_done_s", 16'(done_s), 16'd1);
    chk("e9_done_u", 16'(done_u), 16'd1);
    chk("e9_ready", 16'(ready_s), 16'd1);
    chk("e9_prod_s", product_s, es);
    chk("e9_prod_u", product_u, eu);
    prev_s = es;
    prev_u = eu;
    if (!chain) begin
      start = 1'b0;
      @(posedge clk); #1;
      chk("e10_done", 16'(done_s), 16'd0);
      chk("e10_ready", 16'(ready_s), 16'd1);
      chk("e10_prod_s", product_s, prev_s);
      chk("e10_prod_u", product_u, prev_u);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    prev_s = '0;
    prev_u = '0;
    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    #7;
    chk("rst_prod", product_s, 16'h0000);
    chk("rst_ready", 16'(ready_s), 16'd1);
    chk("rst_done", 16'(done_s), 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(8'd7, 8'd3, 1'b0, 1'b0);
    chk("tp_7x3", product_s, 16'h0015);
    run(8'hFA, 8'd5, 1'b0, 1'b0);
    chk("tp_m6x5", product_s, 16'hFFE2);
    run(8'h80, 8'h80, 1'b0, 1'b0);
    chk("tp_m128sq", product_s, 16'h4000);
    run(8'h80, 8'h7F, 1'b0, 1'b0);
    chk("tp_m128x127", product_s, 16'hC080);
    run(8'hFB, 8'h00, 1'b0, 1'b0);
    chk("tp_m5x0", product_s, 16'h0000);
    run(8'hFF, 8'hFF, 1'b0, 1'b0);
    chk("tp_u_ff", product_u, 16'hFE01);
    run(8'h80, 8'h02, 1'b0, 1'b0);
    chk("tp_u_80x2", product_u, 16'h0100);

    run(8'd11, 8'hF3, 1'b1, 1'b0);

    start = 1'b1;
    multiplicand = 8'd9;
    multiplier = 8'd9;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #2;
    chk("abort_prod", product_s, 16'h0000);
    chk("abort_ready", 16'(ready_s), 16'd1);
    chk("abort_done", 16'(done_s), 16'd0);
    prev_s = '0;
    prev_u = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(8'd2, 8'd3, 1'b0, 1'b0);
    chk("after_rst", product_s, 16'h0006);

    run(8'd10, 8'd10, 1'b0, 1'b1);
    chk("b2b_first", product_s, 16'h0064);
    run(8'hFD, 8'd4, 1'b0, 1'b0);
    chk("b2b_second", product_s, 16'hFFF4);

    for (int n = 0; n < 20; n++) begin
      run(8'($urandom), 8'($urandom), 1'b0, ($urandom_range(0, 1) == 1) && (n < 19));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
